// File: rtl/lc3b_types.sv
// Shared LC-3b types used by the physical-memory side of the cache hierarchy.
package lc3b_types;

  // One cache line as moved over the physical-memory interface.
  typedef logic [127:0] lc3b_burst;

  // Byte address presented on the physical-memory interface.
  typedef logic [15:0] lc3b_pmem_addr;

  // Responder transaction state.
  typedef enum logic [1:0] {
    pmem_idle,
    pmem_busy,
    pmem_resp
  } lc3b_pmem_state;

  // Low address bits that select a byte inside a line and are ignored.
  localparam int PMEM_OFFSET_W = 4;

endpackage

// File: rtl/pmem_line_array.sv
// Line storage for the memory responder: synchronous write, synchronous
// registered read, no reset on either the array or the read register.
module pmem_line_array
  import lc3b_types::lc3b_burst;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic            re,
  input  logic [AW-1:0]   addr,
  input  lc3b_burst       wdata,
  output lc3b_burst       rdata
);

  lc3b_burst mem [DEPTH];

  // Write the addressed line, or capture it into the read register.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/lc3b_pmem_responder.sv
// Fixed-latency burst-memory responder standing in for main memory below the
// LC-3b caches. Serves 128-bit line reads/writes, counts completions and
// flags initiator protocol violations.
module lc3b_pmem_responder
  import lc3b_types::lc3b_burst;
  import lc3b_types::lc3b_pmem_addr;
  import lc3b_types::lc3b_pmem_state;
  import lc3b_types::pmem_idle;
  import lc3b_types::pmem_busy;
  import lc3b_types::PMEM_OFFSET_W;
#(
  parameter int LATENCY = 4,
  parameter int DEPTH   = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  lc3b_pmem_addr pmem_address,
  input  logic          pmem_read,
  input  logic          pmem_write,
  input  lc3b_burst     pmem_wdata,
  output lc3b_burst     pmem_rdata,
  output logic          pmem_resp,
  output logic          protocol_err,
  output logic [15:0]   read_count,
  output logic [15:0]   write_count
);

  localparam int         AW     = $clog2(DEPTH);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  lc3b_pmem_state state;
  logic [3:0]     cnt;
  logic           op_wr_q;
  logic           rd_valid;
  logic [AW-1:0]  idx_q;
  lc3b_burst      wdata_q;

  logic           req;
  logic [AW-1:0]  in_idx;
  logic           fire_idle;
  logic           fire_busy;
  logic           fire;
  logic           changed;
  logic           arr_we;
  logic           arr_re;
  logic [AW-1:0]  arr_addr;
  lc3b_burst      arr_wdata;
  lc3b_burst      arr_rdata;
  logic           unused_addr;

  assign req    = pmem_read | pmem_write;
  // Offset bits and index bits above the array size wrap silently.
  assign in_idx = pmem_address[PMEM_OFFSET_W +: AW];
  assign unused_addr = ^pmem_address;

  // The array is touched only on the edge that enters RESP. With a
  // single-cycle latency that edge is the acceptance edge itself, so the
  // live inputs are used instead of the latched copies.
  assign fire_idle = (state == pmem_idle) && req && (LATENCY == 1);
  assign fire_busy = (state == pmem_busy) && req && (cnt == 4'd1);
  assign fire      = rst_n && (fire_idle || fire_busy);
  assign arr_we    = fire && (fire_idle ? pmem_write : op_wr_q);
  assign arr_re    = fire && !(fire_idle ? pmem_write : op_wr_q);
  assign arr_addr  = fire_idle ? in_idx : idx_q;
  assign arr_wdata = fire_idle ? pmem_wdata : wdata_q;

  // Any drift of the held request away from what was accepted.
  assign changed = (in_idx != idx_q) || (pmem_write != op_wr_q) ||
                   (pmem_wdata != wdata_q);

  // Until a read has completed the read register holds garbage, so the
  // output is forced to zero; afterwards it follows the registered line.
  assign pmem_rdata = rd_valid ? arr_rdata : '0;

  pmem_line_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .re    (arr_re),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .rdata (arr_rdata)
  );

  // Capture request address and write line at acceptance (data, no reset).
  always_ff @(posedge clk) begin
    if (state == pmem_idle && req) begin
      idx_q   <= in_idx;
      wdata_q <= pmem_wdata;
    end
  end

  // Transaction FSM, latency counter, error flag and completion counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= pmem_idle;
      cnt          <= 4'd0;
      op_wr_q      <= 1'b0;
      pmem_resp    <= 1'b0;
      protocol_err <= 1'b0;
      rd_valid     <= 1'b0;
      read_count   <= 16'd0;
      write_count  <= 16'd0;
    end else begin
      pmem_resp <= fire;
      if (arr_re) begin
        rd_valid <= 1'b1;
      end
      case (state)
        pmem_idle: begin
          if (req) begin
            cnt     <= LAT_M1;
            op_wr_q <= pmem_write;
            if (pmem_read && pmem_write) begin
              protocol_err <= 1'b1;
            end
            if (LATENCY == 1) begin
              state <= lc3b_types::pmem_resp;
            end else begin
              state <= pmem_busy;
            end
          end
        end
        pmem_busy: begin
          if (!req) begin
            state        <= pmem_idle;
            protocol_err <= 1'b1;
          end else begin
            if (changed) begin
              protocol_err <= 1'b1;
            end
            if (cnt == 4'd1) begin
              state <= lc3b_types::pmem_resp;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
        end
        lc3b_types::pmem_resp: begin
          state <= pmem_idle;
          if (op_wr_q) begin
            write_count <= write_count + 16'd1;
          end else begin
            read_count <= read_count + 16'd1;
          end
        end
        default: state <= pmem_idle;
      endcase
    end
  end

endmodule

// File: tb/tb_lc3b_pmem_responder.sv
// Bench for lc3b_pmem_responder: table of directed line transactions,
// randomized traffic against a line-array model, and hand-written abort,
// reset and single-cycle-latency sequences.
module tb_lc3b_pmem_responder;

  localparam int LAT = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [15:0]  pmem_address;
  logic         pmem_read, pmem_write;
  logic [127:0] pmem_wdata, pmem_rdata;
  logic         pmem_resp, protocol_err;
  logic [15:0]  read_count, write_count;

  logic [15:0]  p1_address;
  logic         p1_read, p1_write;
  logic [127:0] p1_wdata, p1_rdata;
  logic         p1_resp, p1_err;
  logic [15:0]  p1_rcnt, p1_wcnt;

  always #5 clk = ~clk;

  lc3b_pmem_responder #(.LATENCY(LAT), .DEPTH(64)) dut (
    .clk(clk), .rst_n(rst_n), .pmem_address(pmem_address),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp), .protocol_err(protocol_err),
    .read_count(read_count), .write_count(write_count));

  lc3b_pmem_responder #(.LATENCY(1), .DEPTH(64)) dut1 (
    .clk(clk), .rst_n(rst_n), .pmem_address(p1_address),
    .pmem_read(p1_read), .pmem_write(p1_write), .pmem_wdata(p1_wdata),
    .pmem_rdata(p1_rdata), .pmem_resp(p1_resp), .protocol_err(p1_err),
    .read_count(p1_rcnt), .write_count(p1_wcnt));

  int checks = 0;
  int errors = 0;

  // Behavioural model: line store, completion counts, sticky error.
  logic [127:0] mdl_mem [64];
  bit           mdl_vld [64];
  int           mdl_rd_cnt, mdl_wr_cnt;
  logic         mdl_err;

  typedef struct {
    logic         rd;
    logic         wr;
    logic [15:0]  addr;
    logic [127:0] wd;
    logic [127:0] exp_rd;
    logic         exp_err;
  } vec_t;
  vec_t tbl [10];

  task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Issue one request on the LATENCY=4 port and hold it until pmem_resp.
  // Called and returns at a falling edge; updates the model on completion.
  task automatic txn(input logic rd, input logic wr, input logic [15:0] a,
                     input logic [127:0] wd, output logic [127:0] got);
    int lat;
    int idx;
    lat = -1;
    got = 'x;
    pmem_read = rd; pmem_write = wr; pmem_address = a; pmem_wdata = wd;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (pmem_resp) begin
        lat = n;
        got = pmem_rdata;
        break;
      end
    end
    pmem_read = 1'b0; pmem_write = 1'b0;
    check("resp_latency", 128'(lat), 128'(LAT));
    @(negedge clk);
    check("resp_pulse_width", 128'(pmem_resp), 128'd0);
    if (lat > 0) begin
      idx = (int'(a) / 16) % 64;
      if (wr) begin
        mdl_mem[idx] = wd;
        mdl_vld[idx] = 1'b1;
        mdl_wr_cnt++;
      end else begin
        mdl_rd_cnt++;
      end
      if (rd && wr) mdl_err = 1'b1;
    end
    check("read_count", 128'(read_count), 128'(mdl_rd_cnt % 65536));
    check("write_count", 128'(write_count), 128'(mdl_wr_cnt % 65536));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    pmem_read = 1'b0; pmem_write = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mdl_rd_cnt = 0; mdl_wr_cnt = 0; mdl_err = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    logic [127:0] got, last_rd, val_a;
    logic         seen;
    logic [1:0]   resp_seq;
    int           op, idx;
    logic [15:0]  a;
    logic [127:0] wd;

    rst_n = 1'b0;
    pmem_address = '0; pmem_read = 1'b0; pmem_write = 1'b0; pmem_wdata = '0;
    p1_address = '0; p1_read = 1'b0; p1_write = 1'b0; p1_wdata = '0;
    mdl_rd_cnt = 0; mdl_wr_cnt = 0; mdl_err = 1'b0;
    for (int i = 0; i < 64; i++) mdl_vld[i] = 1'b0;

    tbl[0] = '{1'b0, 1'b1, 16'h0040, 128'h0123456789ABCDEF0123456789ABCDEF, 128'h0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 16'h0040, 128'h0, 128'h0123456789ABCDEF0123456789ABCDEF, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 16'h004F, 128'h0, 128'h0123456789ABCDEF0123456789ABCDEF, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 16'h0400, 128'hFEEDFACE_00000000_11111111_22222222, 128'h0, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 16'h0000, 128'h0, 128'hFEEDFACE_00000000_11111111_22222222, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 16'h0400, 128'h0, 128'hFEEDFACE_00000000_11111111_22222222, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 16'hFC50, 128'h5555_0000_5555_0000_5555_0000_5555_0000, 128'h0, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 16'h0050, 128'h0, 128'h5555_0000_5555_0000_5555_0000_5555_0000, 1'b0};
    tbl[8] = '{1'b1, 1'b1, 16'h0080, 128'hAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAA, 128'h0, 1'b1};
    tbl[9] = '{1'b1, 1'b0, 16'h0080, 128'h0, 128'hAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAA, 1'b1};

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_resp", 128'(pmem_resp), 128'd0);
    check("rst_rdata", pmem_rdata, 128'd0);
    check("rst_err", 128'(protocol_err), 128'd0);
    check("rst_read_count", 128'(read_count), 128'd0);
    check("rst_write_count", 128'(write_count), 128'd0);
    check("rst_l1_resp", 128'(p1_resp), 128'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Abort: request dropped in cycle 2 of 4.
    pmem_read = 1'b1; pmem_address = 16'h0040;
    @(negedge clk);
    @(negedge clk);
    pmem_read = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen = seen | pmem_resp;
    end
    check("abort_no_resp", 128'(seen), 128'd0);
    check("abort_err", 128'(protocol_err), 128'd1);
    check("abort_read_count", 128'(read_count), 128'd0);
    txn(1'b0, 1'b1, 16'h0040, 128'h0123456789ABCDEF0123456789ABCDEF, got);

    // Directed table, starting from a clean error flag.
    do_reset();
    last_rd = '0;
    for (int i = 0; i < 10; i++) begin
      txn(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wd, got);
      if (tbl[i].rd && !tbl[i].wr) begin
        check($sformatf("tbl%0d_rdata", i), got, tbl[i].exp_rd);
        last_rd = tbl[i].exp_rd;
      end else begin
        check($sformatf("tbl%0d_rdata_hold", i), pmem_rdata, last_rd);
      end
      check($sformatf("tbl%0d_err", i), 128'(protocol_err), 128'(tbl[i].exp_err));
    end

    // Randomized traffic against the model.
    for (int k = 0; k < 40; k++) begin
      op = int'($urandom_range(0, 5));
      a  = 16'($urandom);
      wd = {$urandom, $urandom, $urandom, $urandom};
      idx = (int'(a) / 16) % 64;
      if (op < 3 && mdl_vld[idx]) begin
        txn(1'b1, 1'b0, a, wd, got);
        check($sformatf("rnd%0d_rdata", k), got, mdl_mem[idx]);
      end else begin
        txn(op == 5, 1'b1, a, wd, got);
      end
      check($sformatf("rnd%0d_err", k), 128'(protocol_err), 128'(mdl_err));
    end

    // Reset asserted during BUSY of a write: nothing may be written.
    do_reset();
    val_a = 128'h0DDBA11_0000_CAFE_0000_BEEF_0000_1234;
    txn(1'b0, 1'b1, 16'h0050, val_a, got);
    pmem_write = 1'b1; pmem_address = 16'h0050;
    pmem_wdata = 128'hDEAD_DEAD_DEAD_DEAD_DEAD_DEAD_DEAD_DEAD;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    pmem_write = 1'b0;
    #1;
    check("midrst_resp", 128'(pmem_resp), 128'd0);
    check("midrst_rdata", pmem_rdata, 128'd0);
    check("midrst_err", 128'(protocol_err), 128'd0);
    check("midrst_write_count", 128'(write_count), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mdl_rd_cnt = 0; mdl_wr_cnt = 0; mdl_err = 1'b0;
    @(negedge clk);
    txn(1'b1, 1'b0, 16'h0050, 128'h0, got);
    check("midrst_line_kept", got, val_a);

    // LATENCY=1: one write, then back-to-back reads.
    p1_write = 1'b1; p1_address = 16'h0010;
    p1_wdata = 128'h0F0F_1E1E_2D2D_3C3C_4B4B_5A5A_6969_7878;
    @(negedge clk);
    check("l1_write_resp", 128'(p1_resp), 128'd1);
    p1_write = 1'b0;
    @(negedge clk);
    check("l1_write_resp_end", 128'(p1_resp), 128'd0);
    p1_read = 1'b1;
    resp_seq = '0;
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      if (n == 1) begin
        resp_seq[0] = p1_resp;
        check("l1_rd1_data", p1_rdata, 128'h0F0F_1E1E_2D2D_3C3C_4B4B_5A5A_6969_7878);
      end else if (n == 2) begin
        check("l1_gap_resp", 128'(p1_resp), 128'd0);
        check("l1_rdata_hold", p1_rdata, 128'h0F0F_1E1E_2D2D_3C3C_4B4B_5A5A_6969_7878);
      end else begin
        resp_seq[1] = p1_resp;
        p1_read = 1'b0;
      end
    end
    check("l1_resp_cycles_1_3", 128'(resp_seq), 128'd3);
    @(negedge clk);
    check("l1_read_count", 128'(p1_rcnt), 128'd2);
    check("l1_write_count", 128'(p1_wcnt), 128'd1);
    check("l1_err", 128'(p1_err), 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lc3b_pmem_responder.md
# lc3b_pmem_responder

Burst-memory responder at the far end of the L1 cache's physical-memory interface. It accepts 128-bit line reads and writes (`lc3b_burst`) from the cache and serves them from an internal line array. Each response comes back after a fixed, parameterised latency as a one-cycle `pmem_resp` pulse. It stands in for main memory beneath the LC-3b pipeline's caches and also reports protocol violations by the initiator.

## Interface
- `LATENCY`, default 4: cycles from request acceptance to `pmem_resp`. Legal range 1..15.
- `DEPTH`, default 64: number of 128-bit lines. Must be a power of two, ≤ 4096.
- `clk`  in  1  single clock; everything changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `pmem_address`  in  16  byte address; bits [3:0] are ignored (line-aligned).
- `pmem_read`  in  1  read request, held high until `pmem_resp`.
- `pmem_write`  in  1  write request, held high until `pmem_resp`.
- `pmem_wdata`  in  128  write line, type `lc3b_burst`.
- `pmem_rdata`  out  128  read line, registered.
- `pmem_resp`  out  1  one-cycle completion pulse.
- `protocol_err`  out  1  sticky violation flag, cleared only by reset.
- `read_count`  out  16  completed reads, wraps modulo 2^16.
- `write_count`  out  16  completed writes, wraps modulo 2^16.

## Operation
- States: `IDLE`, `BUSY`, `RESP`.
- **IDLE**
  - If `pmem_read|pmem_write` is sampled high, latch the request: address index = `pmem_address[4 +: log2(DEPTH)]`, with higher bits dropped (modulo wrap). Also latch `pmem_wdata` and the op.
  - Load the counter with `LATENCY-1`.
  - Go to `RESP` if `LATENCY==1`, else `BUSY`.
- **BUSY**
  - Decrement the counter each cycle. At 1, go to `RESP`.
  - If the request is observed low (`pmem_read|pmem_write==0`) → abort: return to `IDLE`, no array write, no resp, no count change, set `protocol_err`.
- **RESP**
  - `pmem_resp=1` for exactly this cycle.
  - Write: the array line is written at the edge entering `RESP`.
  - Read: `pmem_rdata` is loaded at that same edge and holds until the next read completes.
  - Increment the matching counter. Next state is `IDLE`.
- Read and write both high at acceptance: serve as a write and set `protocol_err`.
- Address, op, or `pmem_wdata` changing during `BUSY`: the latched values are used and `protocol_err` is set. Address comparison uses the line index only.
- Request still high in the cycle after `RESP`: treated as a new request (back-to-back is legal).
- Array contents are not reset; they are undefined until written.

## Timing
- The request is first visible in cycle 0. `pmem_resp` is high in cycle `LATENCY`, and read data is valid in that same cycle.
- Minimum spacing between responses is `LATENCY+1` cycles.
- Reset values: `pmem_resp=0`, `pmem_rdata=0`, `protocol_err=0`, both counts 0, state `IDLE`.
- Reset mid-operation: the in-flight op is discarded and the array is not written.
- All outputs are registered; there is no combinational input→output path.

## Structure
- Add to `lc3b_types`:
  - `typedef enum` `lc3b_pmem_state` {`pmem_idle`, `pmem_busy`, `pmem_resp`}.
  - `lc3b_pmem_addr` (16-bit).
  - Reuse the existing `lc3b_burst`.
- One sub-module, `pmem_line_array`: synchronous-write, synchronous-read DEPTH×128 storage with no reset.
- The FSM, latency counter, error logic and stat counters live in the top-level block.

## Test plan
- Reset, then write 0x0123…CDEF to 0x0040, then read 0x0040 (`LATENCY=4`) → `pmem_resp` in cycles 4 and 4; read returns 0x0123…CDEF; `write_count=1`, `read_count=1`.
- Read 0x004F after writing 0x0040 → same line returned (offset ignored). Write 0x0400 with `DEPTH=64` → aliases line 0.
- Drop `pmem_read` in cycle 2 of 4 → no resp, `protocol_err=1`, `read_count` unchanged, next request served normally.
- Assert read and write together with `wdata`=0xAAAA… → write performed, `protocol_err=1`.
- Back-to-back reads with `LATENCY=1` → resp in cycles 1 and 3; `read_count` reaches 2; `pmem_rdata` holds between them.
- Assert `rst_n` low during `BUSY` of a write → outputs return to reset values; a following read of that line shows no write occurred.
